// File: rtl/mips_pkg.sv
// Shared constants, opcodes and fetch state encoding for the MIPS-like pipeline.
package mips_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  localparam logic [5:0] OP_JUMP = 6'b010000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000110;
  localparam logic [5:0] OP_LD   = 6'b100010;
  localparam logic [5:0] OP_LDI  = 6'b100011;
  localparam logic [5:0] OP_ST   = 6'b101010;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational jump predecoder: flags OP_JUMP and extracts the word-address target.
module fetch_predecode
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] target_field,
  output logic              is_jump,
  output logic [ADDR_W-1:0] target
);

  assign is_jump = (opcode == OP_JUMP);
  assign target  = target_field;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, instruction-memory address, fetch/decode register with valid/ready.
// Optional jump predecode redirect is enabled by defining FETCH_JUMP_PREDECODE_EN.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W    = mips_pkg::ADDR_W,
  parameter int unsigned       DATA_W    = mips_pkg::DATA_W,
  parameter int unsigned       MEM_DEPTH = 81,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] instrucao,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus1,
  output logic              id_predicted,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              id_valid_q, id_valid_d;
  logic [DATA_W-1:0] id_instr_q, id_instr_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [ADDR_W-1:0] id_pc_plus1_q, id_pc_plus1_d;
  logic              id_predicted_q, id_predicted_d;
  logic [15:0]       fetch_count_q, fetch_count_d;

  logic              slot_free;
  logic              end_of_prog;
  logic              capture;
  logic [ADDR_W-1:0] pc_plus1;
  logic              pred_jump;
  logic [ADDR_W-1:0] pred_target;

`ifdef FETCH_JUMP_PREDECODE_EN
  fetch_predecode #(
    .ADDR_W(ADDR_W)
  ) u_predecode (
    .opcode      (instrucao[DATA_W-1 -: 6]),
    .target_field(instrucao[ADDR_W-1:0]),
    .is_jump     (pred_jump),
    .target      (pred_target)
  );
`else
  assign pred_jump   = 1'b0;
  assign pred_target = '0;
`endif

  assign slot_free   = !id_valid_q || id_ready;
  assign end_of_prog = (32'(pc_q) >= MEM_DEPTH);
  assign pc_plus1    = pc_q + ADDR_W'(1);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    id_valid_d     = id_valid_q;
    id_instr_d     = id_instr_q;
    id_pc_d        = id_pc_q;
    id_pc_plus1_d  = id_pc_plus1_q;
    id_predicted_d = id_predicted_q;
    fetch_count_d  = fetch_count_q;
    capture        = 1'b0;

    unique case (state_q)
      // Memory loads on its first edge, so nothing is captured in BOOT.
      BOOT: begin
        state_d = RUN;
        if (redirect_valid) pc_d = redirect_addr;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_d       = redirect_addr;
          id_valid_d = 1'b0;
        end else if (halt) begin
          state_d = HALTED;
          if (id_ready) id_valid_d = 1'b0;
        end else if (end_of_prog && slot_free) begin
          state_d    = HALTED;
          id_valid_d = 1'b0;
        end else if (slot_free) begin
          capture = 1'b1;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          pc_d       = redirect_addr;
          id_valid_d = 1'b0;
          state_d    = RUN;
        end else if (id_ready) begin
          id_valid_d = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase

    if (capture) begin
      id_instr_d     = instrucao;
      id_pc_d        = pc_q;
      id_pc_plus1_d  = pc_plus1;
      id_valid_d     = 1'b1;
      id_predicted_d = pred_jump;
      pc_d           = pred_jump ? pred_target : pc_plus1;
      if (fetch_count_q != 16'hFFFF) fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= BOOT;
      pc_q           <= RESET_PC;
      id_valid_q     <= 1'b0;
      id_instr_q     <= '0;
      id_pc_q        <= '0;
      id_pc_plus1_q  <= '0;
      id_predicted_q <= 1'b0;
      fetch_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      id_valid_q     <= id_valid_d;
      id_instr_q     <= id_instr_d;
      id_pc_q        <= id_pc_d;
      id_pc_plus1_q  <= id_pc_plus1_d;
      id_predicted_q <= id_predicted_d;
      fetch_count_q  <= fetch_count_d;
    end
  end

  assign address      = pc_q;
  assign id_valid     = id_valid_q;
  assign id_instr     = id_instr_q;
  assign id_pc        = id_pc_q;
  assign id_pc_plus1  = id_pc_plus1_q;
  assign id_predicted = id_predicted_q;
  assign halted       = (state_q == HALTED);
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed pins plus randomized run vs a reference model.
module tb_instruction_fetch;

  logic        clock;
  logic        reset;
  logic        halt;
  logic        redirect_valid;
  logic [9:0]  redirect_addr;
  logic [9:0]  address;
  logic [31:0] instrucao;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [9:0]  id_pc;
  logic [9:0]  id_pc_plus1;
  logic        id_predicted;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int passes = 0;

  instruction_fetch dut (
    .clock         (clock),
    .reset         (reset),
    .halt          (halt),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .address       (address),
    .instrucao     (instrucao),
    .id_ready      (id_ready),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc_plus1   (id_pc_plus1),
    .id_predicted  (id_predicted),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  assign instrucao = mem[address];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: st 0=boot 1=run 2=halted; integer arithmetic on the PC.
  typedef struct {
    int          st;
    int          pc;
    bit          v;
    logic [31:0] instr;
    int          ipc;
    int          ipc1;
    bit          pred;
    int          cnt;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.st = 0; r.pc = 0; r.v = 0; r.instr = '0; r.ipc = 0; r.ipc1 = 0; r.pred = 0; r.cnt = 0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t c, bit rv, int ra, bit hl, bit rdy);
    mdl_t n = c;
    bit free = !c.v || rdy;
    logic [31:0] w;
    if (c.st == 0) begin
      n.st = 1;
      if (rv) n.pc = ra;
    end else if (c.st == 1) begin
      if (rv) begin
        n.pc = ra; n.v = 0;
      end else if (hl) begin
        n.st = 2;
        if (rdy) n.v = 0;
      end else if (c.pc >= 81 && free) begin
        n.st = 2; n.v = 0;
      end else if (free) begin
        w = mem[c.pc];
        n.v = 1; n.instr = w; n.ipc = c.pc; n.ipc1 = (c.pc + 1) % 1024;
        n.pc = (c.pc + 1) % 1024;
        n.pred = 0;
`ifdef FETCH_JUMP_PREDECODE_EN
        if (w[31:26] == 6'b010000) begin
          n.pc = int'(w[9:0]);
          n.pred = 1;
        end
`endif
        if (c.cnt < 65535) n.cnt = c.cnt + 1;
      end
    end else begin
      if (rv) begin
        n.pc = ra; n.v = 0; n.st = 1;
      end else if (rdy) begin
        n.v = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m <= mdl_reset();
    else m <= step(m, redirect_valid, int'(redirect_addr), halt, id_ready);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      check("model address", 32'(address), 32'(m.pc));
      check("model id_valid", 32'(id_valid), 32'(m.v));
      check("model halted", 32'(halted), 32'(m.st == 2));
      check("model fetch_count", 32'(fetch_count), 32'(m.cnt));
      if (m.v) begin
        check("model id_instr", id_instr, m.instr);
        check("model id_pc", 32'(id_pc), 32'(m.ipc));
        check("model id_pc_plus1", 32'(id_pc_plus1), 32'(m.ipc1));
        check("model id_predicted", 32'(id_predicted), 32'(m.pred));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic redirect_to(input int a);
    redirect_valid = 1'b1;
    redirect_addr  = 10'(a);
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem[9] = 32'h4000_0005;
    for (int i = 11; i < 78; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 7) == 0) mem[i][31:26] = 6'b010000;
    end

    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; id_ready = 1'b1;
    #1;
    check("reset id_valid", 32'(id_valid), 32'd0);
    check("reset halted", 32'(halted), 32'd0);
    check("reset fetch_count", 32'(fetch_count), 32'd0);
    check("reset address", 32'(address), 32'd0);
    check("reset id_instr", id_instr, 32'd0);
    #11 reset = 1'b0;

    // Boot cycle then three back-to-back captures
    tick();
    check("boot no capture", 32'(id_valid), 32'd0);
    tick();
    check("first capture valid", 32'(id_valid), 32'd1);
    check("first capture pc", 32'(id_pc), 32'd0);
    check("first capture instr", id_instr, 32'h1000_0000);
    tick(); tick();
    check("third capture pc", 32'(id_pc), 32'd2);
    check("count after 3", 32'(fetch_count), 32'd3);
    check("address after 3", 32'(address), 32'd3);

    // Decode back-pressure
    id_ready = 1'b0;
    repeat (4) tick();
    check("stall address", 32'(address), 32'd3);
    check("stall id_pc", 32'(id_pc), 32'd2);
    check("stall count", 32'(fetch_count), 32'd3);
    id_ready = 1'b1;
    tick();
    check("release id_pc", 32'(id_pc), 32'd3);

    // Redirect while stalled flushes the held instruction
    id_ready = 1'b0;
    redirect_to(5);
    check("flush id_valid", 32'(id_valid), 32'd0);
    check("flush address", 32'(address), 32'd5);
    id_ready = 1'b1;
    tick();
    check("target id_pc", 32'(id_pc), 32'd5);
    check("target pc_plus1", 32'(id_pc_plus1), 32'd6);

    // End of program
    redirect_to(78);
    repeat (3) tick();
    check("last capture pc", 32'(id_pc), 32'd80);
    tick();
    check("end halted", 32'(halted), 32'd1);
    check("end id_valid", 32'(id_valid), 32'd0);
    check("end count", 32'(fetch_count), 32'd8);
    redirect_to(10);
    check("resume halted", 32'(halted), 32'd0);
    tick();
    check("resume id_pc", 32'(id_pc), 32'd10);

    // Jump word at address 9
    redirect_to(9);
    tick();
    check("jump id_pc", 32'(id_pc), 32'd9);
`ifdef FETCH_JUMP_PREDECODE_EN
    check("jump address", 32'(address), 32'd5);
    check("jump predicted", 32'(id_predicted), 32'd1);
`else
    check("jump address", 32'(address), 32'd10);
    check("jump predicted", 32'(id_predicted), 32'd0);
`endif

    // Asynchronous reset mid-cycle while fetching PC 6
    redirect_to(6);
    tick();
    #2 reset = 1'b1;
    #1;
    check("async id_valid", 32'(id_valid), 32'd0);
    check("async address", 32'(address), 32'd0);
    check("async count", 32'(fetch_count), 32'd0);
    check("async id_pc", 32'(id_pc), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post-reset boot", 32'(id_valid), 32'd0);
    tick();
    check("post-reset first pc", 32'(id_pc), 32'd0);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      id_ready       = ($urandom_range(0, 9) < 7);
      halt           = ($urandom_range(0, 99) < 3);
      redirect_valid = ($urandom_range(0, 99) < 5);
      redirect_addr  = 10'($urandom_range(0, 90));
      tick();
    end
    halt = 1'b0; redirect_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage that sits directly upstream of the instruction memory and feeds the decode stage.
- Holds the program counter and drives the 10-bit word address to instruction memory.
- Captures the returned 32-bit instruction into a fetch/decode register with a valid/ready handshake.
- Handles redirects from execute (branch/jump), decode back-pressure, end-of-program and halt.

Parameters:
ADDR_W, 10, word-address width (PC width)
DATA_W, 32, instruction width
MEM_DEPTH, 81, number of valid instruction words; PC >= MEM_DEPTH means end of program
RESET_PC, 0, PC value after reset

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high reset
halt  in  1  request to stop fetching (sampled each edge)
redirect_valid  in  1  execute requests PC redirect (taken beq/bne, jump)
redirect_addr  in  ADDR_W  redirect target word address
address  out  ADDR_W  word address to instruction memory (= PC, combinational from PC register)
instrucao  in  DATA_W  instruction returned by memory (combinational read of address)
id_ready  in  1  decode can accept the fetch/decode register this cycle
id_valid  out  1  fetch/decode register holds a valid instruction
id_instr  out  DATA_W  fetched instruction
id_pc  out  ADDR_W  address the instruction was fetched from
id_pc_plus1  out  ADDR_W  id_pc + 1, modulo 2^ADDR_W
id_predicted  out  1  PC was already redirected by the fetch predecoder (see Optional Feature)
halted  out  1  state == HALTED
fetch_count  out  16  instructions captured since reset, saturating at 0xFFFF

Behaviour:
- Reset (async, active-high) sets PC=RESET_PC, state=BOOT and fetch_count=0. All id_* outputs and halted are 0.
- States are BOOT, RUN and HALTED.
- BOOT lasts exactly one cycle with no capture, because instruction memory loads its contents on its first clock edge.
  - BOOT -> RUN unconditionally.
  - If redirect_valid is high in BOOT, PC<=redirect_addr.
- "Slot free" means !id_valid || id_ready.
- RUN, evaluated each edge in priority order:
  1. redirect_valid: PC<=redirect_addr, id_valid<=0 (flush, even if id_ready is low). No capture. Stay RUN.
  2. halt: state<=HALTED, no capture. The id register is held until accepted; id_valid clears on acceptance.
  3. PC >= MEM_DEPTH and slot free: state<=HALTED, id_valid<=0.
  4. Slot free: capture instruction and advance.
     - id_instr<=instrucao, id_pc<=PC, id_pc_plus1<=PC+1, id_valid<=1.
     - PC<=PC+1, wrapping modulo 2^ADDR_W.
     - fetch_count+=1, saturating.
  5. Otherwise (stall): hold PC and all id_* outputs unchanged.
- HALTED:
  - No capture.
  - id_valid clears when id_ready is sampled high.
  - redirect_valid: PC<=redirect_addr, id_valid<=0, state<=RUN.
  - halt is ignored.
- Latency: an instruction appears in the id register one edge after its address is driven. Throughput is one instruction per cycle with id_ready held high.
- Redirect takes effect the next cycle. The first instruction from the target is valid two edges after redirect_valid.
- A simultaneous redirect and stall: the redirect wins and the stalled instruction is discarded.
- An asynchronous reset mid-stall or mid-redirect returns every register to its reset value immediately.

Optional Feature:
FETCH_JUMP_PREDECODE_EN
- Defined: on capture, if instrucao[31:26]==6'b010000 (jump), then:
  - PC<=instrucao[ADDR_W-1:0] instead of PC+1.
  - id_predicted<=1; otherwise id_predicted<=0.
  - id_pc_plus1 is still PC+1.
  - Execute must suppress its own redirect for instructions with id_predicted=1.
- Not defined: id_predicted is tied to 0 and jumps resolve only through redirect_valid.

Decomposition:
- Shared package mips_pkg holds:
  - ADDR_W and DATA_W constants.
  - Opcode constants: OP_JUMP=6'b010000, OP_BEQ=6'b000100, OP_BNE=6'b000110, OP_LD=6'b100010, OP_LDI=6'b100011, OP_ST=6'b101010.
  - fetch state enum {BOOT, RUN, HALTED}.
- One natural sub-module, fetch_predecode: combinational opcode match plus jump-target extraction, instantiated only under FETCH_JUMP_PREDECODE_EN.

Test Plan:
- Reset, then id_ready=1 with memory word n = 32'h1000_0000+n -> BOOT for 1 cycle. id_valid rises on the 2nd edge with id_pc=0, then id_pc=1,2,3 on consecutive cycles. fetch_count=3 after 3 captures.
- Hold id_ready=0 for 4 cycles after id_pc=2 is captured -> address stays 3, id_instr/id_pc unchanged, fetch_count unchanged. Release id_ready -> id_pc=3 on the next edge.
- redirect_valid=1, redirect_addr=5 while id_ready=0 and id_valid=1 -> id_valid=0 next edge, address=5. id_pc=5 one edge later.
- Run from PC 78 with id_ready=1 -> captures 78, 79, 80, then halted=1 and id_valid=0 with no capture at PC 81. A redirect to 10 returns to RUN and fetches 10.
- Word 9 = 32'h4000_0005 with the macro defined -> after capturing 9, address=5 and id_predicted=1. Without the macro, address=10 and id_predicted=0.
- Assert reset asynchronously mid-cycle while fetching PC 6 -> outputs zero immediately, PC=0, state BOOT.
